obi_bridge_arbiter: RTL

Parametrised N-channel arbiter for the host-side bridge port of the gr-heep top (req/we/be/addr/wdata, gnt/rvalid/rdata). It lets several host agents share the single bridge port: testbench drivers, a DMA-style loader and a debug poker. It arbitrates requests round-robin and tracks outstanding transactions in an in-order ID FIFO. Each response is routed back to the channel that issued it. The block sits between the host agents and the `req_i`/`gnt_o`/`rvalid_o` pins of the DUT bridge.

---
 rtl/obi_bridge_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/obi_bridge_arbiter.sv
// obi_bridge_arbiter: round-robin N:1 OBI request arbiter with in-order response routing.
// Latency: request/grant and response routing are combinational (0 cycles); occupancy/err registered.
// Backpressure: a stalled request is locked until granted; req_o is held low while the ID FIFO is full.
//
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   ch_req_i/we/be/addr/wdata          packed per-channel upstream requests (channel k in slice k)
//   ch_gnt_o, ch_rvalid_o, ch_rdata_o  per-channel grant/response, rdata shared and qualified by rvalid
//   req_o/we_o/be_o/addr_o/wdata_o     downstream request to the bridge
//   gnt_i, rvalid_i, rdata_i           downstream grant and response
//   outstanding_o                      granted-but-unanswered transaction count
//   err_o                              sticky: response seen with nothing outstanding

// fifo: generic synchronous FIFO with head-register readout and occupancy count.
// Latency: push visible at head one cycle later; head_dat is a direct register read.
// Backpressure: none internally; caller must not push when full nor pop when empty.
module fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_vld,
  input  logic [Width-1:0] push_dat,
  input  logic             pop_vld,
  output logic [Width-1:0] head_dat,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (push_vld) mem[wr_ptr_q] <= push_dat;
  end

  // Occupancy lives in its own counter so full and empty stay distinct
  // even though both pointers wrap onto the same value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_vld) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_vld)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_vld, pop_vld})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr_q];
  assign count    = cnt_q;
  assign full     = (cnt_q == CntW'(Depth));
  assign empty    = (cnt_q == '0);
endmodule

module obi_bridge_arbiter #(
  parameter int unsigned NumChannels    = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  localparam int unsigned BeW  = DataWidth / 8,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumChannels-1:0]         ch_req_i,
  input  logic [NumChannels-1:0]         ch_we_i,
  input  logic [NumChannels*BeW-1:0]     ch_be_i,
  input  logic [NumChannels*AddrWidth-1:0] ch_addr_i,
  input  logic [NumChannels*DataWidth-1:0] ch_wdata_i,
  output logic [NumChannels-1:0]         ch_gnt_o,
  output logic [NumChannels-1:0]         ch_rvalid_o,
  output logic [DataWidth-1:0]           ch_rdata_o,
  output logic                           req_o,
  output logic                           we_o,
  output logic [BeW-1:0]                 be_o,
  output logic [AddrWidth-1:0]           addr_o,
  output logic [DataWidth-1:0]           wdata_o,
  input  logic                           gnt_i,
  input  logic                           rvalid_i,
  input  logic [DataWidth-1:0]           rdata_i,
  output logic [CntW-1:0]                outstanding_o,
  output logic                           err_o
);
  localparam int unsigned IdW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  logic [IdW-1:0] rr_q, lock_sel_q, rr_sel, sel, head_id;
  logic           locked_q, rr_found, hs, pop, fifo_full, fifo_empty, err_q;

  // Round-robin scan: first requester at or after rr_q, wrapping upward.
  always_comb begin
    rr_sel   = rr_q;
    rr_found = 1'b0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      int unsigned idx;
      idx = 32'(rr_q) + i;
      if (idx >= NumChannels) idx = idx - NumChannels;
      if (!rr_found && ch_req_i[IdW'(idx)]) begin
        rr_found = 1'b1;
        rr_sel   = IdW'(idx);
      end
    end
  end

  // A stalled request keeps its channel so the downstream request stays stable.
  assign sel = locked_q ? lock_sel_q : rr_sel;

  // fifo_full is registered, so a same-cycle pop cannot unblock req_o.
  assign req_o = ch_req_i[sel] & ~fifo_full;
  assign hs    = req_o & gnt_i;
  assign pop   = rvalid_i & ~fifo_empty;

  always_comb begin
    we_o        = 1'b0;
    be_o        = '0;
    addr_o      = '0;
    wdata_o     = '0;
    ch_gnt_o    = '0;
    ch_rvalid_o = '0;
    for (int unsigned k = 0; k < NumChannels; k++) begin
      if (sel == IdW'(k)) begin
        we_o    = ch_we_i[k];
        be_o    = ch_be_i[k*BeW +: BeW];
        addr_o  = ch_addr_i[k*AddrWidth +: AddrWidth];
        wdata_o = ch_wdata_i[k*DataWidth +: DataWidth];
      end
      ch_gnt_o[k]    = hs && (sel == IdW'(k));
      ch_rvalid_o[k] = pop && (head_id == IdW'(k));
    end
  end

  assign ch_rdata_o = rdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      locked_q   <= 1'b0;
      lock_sel_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (hs) begin
        rr_q     <= (sel == IdW'(NumChannels - 1)) ? '0 : sel + 1'b1;
        locked_q <= 1'b0;
      end else if (req_o) begin
        locked_q   <= 1'b1;
        lock_sel_q <= sel;
      end
      // A response with nothing outstanding is dropped and flagged until reset.
      if (rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  fifo #(
    .Width (IdW),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_vld (hs),
    .push_dat (sel),
    .pop_vld  (pop),
    .head_dat (head_id),
    .count    (outstanding_o),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
endmodule
